// File: rtl/cordic_load_seq.sv
// cordic_load_seq: loads the CORDIC coefficient table from a valid/ready
// stream, waits a settling interval, then enables the datapath. It also
// tracks lock on the datapath's first output strobe.
//
// Optional feature: define CORDIC_LOAD_CHECKSUM_EN to add the chk_exp/chk_err
// ports. The block then XORs every accepted word together and refuses to arm
// the datapath when the result does not match chk_exp.
module cordic_load_seq #(
  parameter int unsigned LAST_INDEX = 63,  // index of final table entry
  parameter int unsigned ARM_WAIT   = 8    // ARM cycles before cen
) (
  input  logic        clk,
  input  logic        reset,      // synchronous, active low
  input  logic        start,
  input  logic        stop,
  input  logic        s_valid,
  input  logic [47:0] s_data,
  output logic        s_ready,
  input  logic [15:0] fcw_in,
  input  logic [15:0] offset_in,
  input  logic        cfg_upd,
  input  logic        wen7,
  output logic        wen,
  output logic [5:0]  index_wri,
  output logic [47:0] D,
  output logic [15:0] fcw,
  output logic [15:0] offset,
  output logic        cen,
  output logic        busy,
  output logic        locked,
  output logic        aborted
`ifdef CORDIC_LOAD_CHECKSUM_EN
  ,
  input  logic [47:0] chk_exp,
  output logic        chk_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ARM  = 2'd2,
    RUN  = 2'd3
  } state_t;

  // Frequency word and phase offset always move together.
  typedef struct packed {
    logic [15:0] fcw;
    logic [15:0] offset;
  } cfg_t;

  localparam logic [5:0] LAST_IDX = 6'(LAST_INDEX);
  localparam logic [7:0] ARM_LAST = 8'(ARM_WAIT - 1);

  state_t      state, state_nxt;
  logic [5:0]  wr_cnt;     // next table address to be written
  logic [7:0]  wait_cnt;   // cycles already spent in ARM
  cfg_t        cfg_q;
  logic        hs;         // word accepted this cycle
  logic        last_hs;    // final word of the table accepted this cycle
  logic        start_go;   // IDLE -> LOAD this cycle
  logic        chk_ok;     // checksum agrees (always true without the feature)

`ifdef CORDIC_LOAD_CHECKSUM_EN
  logic [47:0] chk_acc;
  // The final word is folded in here so the comparison can happen on the
  // same edge as the last handshake.
  assign chk_ok = ((chk_acc ^ s_data) == chk_exp);
`else
  assign chk_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs. Stop wins over everything else.
  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    last_hs   = 1'b0;
    start_go  = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b0;
    cen       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          start_go  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (stop) begin
          state_nxt = IDLE;
        end else if (s_valid) begin
          hs = 1'b1;
          if (wr_cnt == LAST_IDX) begin
            last_hs   = 1'b1;
            state_nxt = chk_ok ? ARM : IDLE;
          end
        end
      end
      ARM: begin
        busy = 1'b1;
        if (stop)                       state_nxt = IDLE;
        else if (wait_cnt == ARM_LAST)  state_nxt = RUN;
      end
      RUN: begin
        cen = 1'b1;
        if (stop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Table write port: one write the cycle after each accepted word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wen       <= 1'b0;
      index_wri <= '0;
      D         <= '0;
      wr_cnt    <= '0;
    end else begin
      wen <= hs;
      if (start_go) begin
        wr_cnt <= '0;
      end else if (hs) begin
        index_wri <= wr_cnt;
        D         <= s_data;
        wr_cnt    <= wr_cnt + 6'd1;
      end
    end
  end

  // ARM settling counter. It is held at zero outside ARM, so every ARM entry
  // lasts exactly ARM_WAIT cycles.
  always_ff @(posedge clk) begin
    if (!reset)                                  wait_cnt <= '0;
    else if (state == ARM && state_nxt == ARM)   wait_cnt <= wait_cnt + 8'd1;
    else                                         wait_cnt <= '0;
  end

  // Frequency/offset register. It is captured when the table completes and
  // again on cfg_upd while running. A stop in the same cycle suppresses the
  // update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_q <= '0;
    end else if ((last_hs && chk_ok) || (state == RUN && cfg_upd && !stop)) begin
      cfg_q.fcw    <= fcw_in;
      cfg_q.offset <= offset_in;
    end
  end

  assign fcw    = cfg_q.fcw;
  assign offset = cfg_q.offset;

  // Lock tracks the first output strobe of the current RUN and drops as soon
  // as RUN is left.
  always_ff @(posedge clk) begin
    if (!reset) locked <= 1'b0;
    else        locked <= (state_nxt == RUN) && (locked || (state == RUN && wen7));
  end

  // Abort flag: sticky until the next accepted start. It is set only when a
  // stop interrupts a sequence that had not yet reached RUN.
  always_ff @(posedge clk) begin
    if (!reset)                                      aborted <= 1'b0;
    else if (start_go)                               aborted <= 1'b0;
    else if (stop && (state == LOAD || state == ARM)) aborted <= 1'b1;
  end

`ifdef CORDIC_LOAD_CHECKSUM_EN
  // Running XOR of accepted words. The error flag holds until the next start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      chk_acc <= '0;
      chk_err <= 1'b0;
    end else if (start_go) begin
      chk_acc <= '0;
      chk_err <= 1'b0;
    end else if (hs) begin
      chk_acc <= chk_acc ^ s_data;
      if (last_hs && !chk_ok) chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cordic_load_seq.sv
// Directed, table-driven bench for cordic_load_seq (default parameters).
module tb_cordic_load_seq;

  logic        clk = 1'b0;
  logic        reset, start, stop, s_valid, cfg_upd, wen7;
  logic [47:0] s_data;
  logic [15:0] fcw_in, offset_in;
  logic        s_ready, wen, cen, busy, locked, aborted;
  logic [5:0]  index_wri;
  logic [47:0] D;
  logic [15:0] fcw, offset;
`ifdef CORDIC_LOAD_CHECKSUM_EN
  logic [47:0] chk_exp;
  logic        chk_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cordic_load_seq dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fcw_in(fcw_in), .offset_in(offset_in), .cfg_upd(cfg_upd), .wen7(wen7),
    .wen(wen), .index_wri(index_wri), .D(D), .fcw(fcw), .offset(offset),
    .cen(cen), .busy(busy), .locked(locked), .aborted(aborted)
`ifdef CORDIC_LOAD_CHECKSUM_EN
    , .chk_exp(chk_exp), .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start, stop, s_valid, cfg_upd, wen7;
    logic [47:0] s_data;
    logic [15:0] fcw_in;
    logic        e_wen;
    logic [5:0]  e_idx;
    logic [47:0] e_d;
    logic        e_cen, e_busy, e_srdy, e_lk, e_ab;
    logic [15:0] e_fcw;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic st, sp, sv, input logic [47:0] sd,
                              input logic cu, input logic [15:0] fi, input logic w7,
                              input logic ew, input logic [5:0] ei, input logic [47:0] ed,
                              input logic ec, eb, es, el, ea, input logic [15:0] ef);
    vec_t v;
    v.start = st; v.stop = sp; v.s_valid = sv; v.s_data = sd; v.cfg_upd = cu;
    v.fcw_in = fi; v.wen7 = w7; v.e_wen = ew; v.e_idx = ei; v.e_d = ed;
    v.e_cen = ec; v.e_busy = eb; v.e_srdy = es; v.e_lk = el; v.e_ab = ea; v.e_fcw = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs;
    start = 0; stop = 0; s_valid = 0; cfg_upd = 0; wen7 = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wen"}, wen, 0);         chk({tag, ".idx"}, index_wri, 0);
    chk({tag, ".D"}, D, 0);             chk({tag, ".fcw"}, fcw, 0);
    chk({tag, ".offset"}, offset, 0);   chk({tag, ".cen"}, cen, 0);
    chk({tag, ".s_ready"}, s_ready, 0); chk({tag, ".busy"}, busy, 0);
    chk({tag, ".locked"}, locked, 0);   chk({tag, ".aborted"}, aborted, 0);
  endtask

  // Full 64-word load with s_data = i*3; optional idle cycle between words.
  task automatic load_all(input bit gaps, input bit expect_arm);
    for (int i = 0; i < 64; i++) begin
      s_valid = 1; s_data = 48'(i * 3);
      tick;
      chk($sformatf("ld[%0d].wen", i), wen, 1);
      chk($sformatf("ld[%0d].idx", i), index_wri, i);
      chk($sformatf("ld[%0d].D", i), D, 48'(i * 3));
      if (gaps && i != 63) begin
        s_valid = 0;
        tick;
        chk($sformatf("gap[%0d].wen", i), wen, 0);
        chk($sformatf("gap[%0d].srdy", i), s_ready, 1);
      end
    end
    s_valid = 0;
    chk("ld_end.s_ready", s_ready, 0);
    chk("ld_end.busy", busy, expect_arm);
  endtask

  // Count cycles until cen rises, bounded.
  task automatic wait_cen(output int n);
    n = 0;
    while (cen !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
  endtask

  int n;
  logic [47:0] good_chk;

  initial begin
    reset = 0; clr_inputs; s_data = 0; fcw_in = 16'h0100; offset_in = 16'h0011;
    good_chk = 0;
    for (int i = 0; i < 64; i++) good_chk = good_chk ^ 48'(i * 3);
`ifdef CORDIC_LOAD_CHECKSUM_EN
    chk_exp = good_chk;
`endif

    // Reset state
    tick; tick;
    chk_all_zero("rst");
    reset = 1;

    // Full continuous load, ARM timing, RUN
    start = 1; tick; start = 0;
    chk("st.s_ready", s_ready, 1); chk("st.busy", busy, 1); chk("st.wen", wen, 0);
    load_all(0, 1);
    chk("arm.fcw", fcw, 16'h0100); chk("arm.offset", offset, 16'h0011);
    chk("arm.cen", cen, 0);
    wait_cen(n);
    chk("arm.cycles", n, 8);
    chk("run.busy", busy, 0); chk("run.locked", locked, 0); chk("run.wen", wen, 0);

    // cfg_upd and lock in RUN
    cfg_upd = 1; fcw_in = 16'h0200; offset_in = 16'h0022; tick; cfg_upd = 0;
    chk("upd.fcw", fcw, 16'h0200); chk("upd.offset", offset, 16'h0022);
    fcw_in = 16'h0300; tick;
    chk("noupd.fcw", fcw, 16'h0200);
    wen7 = 1; tick; wen7 = 0;
    chk("lock.set", locked, 1);
    tick;
    chk("lock.hold", locked, 1);

    // Table: stop from RUN, IDLE ignores, start/stop priority, restart, stop in LOAD
    tbl[0]  = mk(0,0,0,48'h0,  0,16'h0300,1, 0,6'd63,48'hBD, 1,0,0,1,0,16'h0200);
    tbl[1]  = mk(0,1,0,48'h0,  1,16'h0999,0, 0,6'd63,48'hBD, 0,0,0,0,0,16'h0200);
    tbl[2]  = mk(0,0,0,48'h0,  1,16'h0777,1, 0,6'd63,48'hBD, 0,0,0,0,0,16'h0200);
    tbl[3]  = mk(1,1,1,48'hAAA,0,16'h0000,0, 0,6'd63,48'hBD, 0,0,0,0,0,16'h0200);
    tbl[4]  = mk(1,0,1,48'hAAA,0,16'h0000,0, 0,6'd63,48'hBD, 0,1,1,0,0,16'h0200);
    tbl[5]  = mk(0,0,1,48'h123,0,16'h0000,0, 1,6'd0, 48'h123,0,1,1,0,0,16'h0200);
    tbl[6]  = mk(1,0,0,48'h0,  0,16'h0000,0, 0,6'd0, 48'h123,0,1,1,0,0,16'h0200);
    tbl[7]  = mk(0,0,1,48'h456,0,16'h0000,1, 1,6'd1, 48'h456,0,1,1,0,0,16'h0200);
    tbl[8]  = mk(0,1,1,48'h789,0,16'h0000,0, 0,6'd1, 48'h456,0,0,0,0,1,16'h0200);
    tbl[9]  = mk(0,0,0,48'h0,  1,16'h0555,0, 0,6'd1, 48'h456,0,0,0,0,1,16'h0200);
    tbl[10] = mk(1,0,0,48'h0,  0,16'h0000,0, 0,6'd1, 48'h456,0,1,1,0,0,16'h0200);
    tbl[11] = mk(0,0,1,48'h9,  1,16'h0666,0, 1,6'd0, 48'h9,  0,1,1,0,0,16'h0200);
    for (int k = 0; k < 12; k++) begin
      start = tbl[k].start; stop = tbl[k].stop; s_valid = tbl[k].s_valid;
      s_data = tbl[k].s_data; cfg_upd = tbl[k].cfg_upd; fcw_in = tbl[k].fcw_in;
      wen7 = tbl[k].wen7;
      tick;
      chk($sformatf("v%0d.wen", k), wen, tbl[k].e_wen);
      chk($sformatf("v%0d.idx", k), index_wri, tbl[k].e_idx);
      chk($sformatf("v%0d.D", k), D, tbl[k].e_d);
      chk($sformatf("v%0d.cen", k), cen, tbl[k].e_cen);
      chk($sformatf("v%0d.busy", k), busy, tbl[k].e_busy);
      chk($sformatf("v%0d.srdy", k), s_ready, tbl[k].e_srdy);
      chk($sformatf("v%0d.locked", k), locked, tbl[k].e_lk);
      chk($sformatf("v%0d.aborted", k), aborted, tbl[k].e_ab);
      chk($sformatf("v%0d.fcw", k), fcw, tbl[k].e_fcw);
    end
    clr_inputs;

    // Stop at word 20, then restart at index 0
    stop = 1; tick; stop = 0;
    start = 1; tick; start = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1; s_data = 48'(i * 3); tick;
      chk($sformatf("w20[%0d].idx", i), index_wri, i);
    end
    s_data = 48'(60); stop = 1; tick; stop = 0;
    chk("stop20.wen", wen, 0); chk("stop20.busy", busy, 0);
    chk("stop20.srdy", s_ready, 0); chk("stop20.aborted", aborted, 1);
    chk("stop20.idx", index_wri, 19); chk("stop20.D", D, 48'd57);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("after20[%0d].wen", i), wen, 0);
    end
    s_valid = 0; start = 1; tick; start = 0;
    chk("restart.aborted", aborted, 0); chk("restart.busy", busy, 1);
    s_valid = 1; s_data = 48'h77; tick; s_valid = 0;
    chk("restart.idx", index_wri, 0); chk("restart.wen", wen, 1);

    // Gapped load, then stop from ARM
    stop = 1; tick; stop = 0;
    start = 1; tick; start = 0;
    load_all(1, 1);
    tick; tick; tick;
    chk("arm3.cen", cen, 0); chk("arm3.busy", busy, 1);
    stop = 1; tick; stop = 0;
    chk("armstop.busy", busy, 0); chk("armstop.cen", cen, 0);
    chk("armstop.aborted", aborted, 1); chk("armstop.wen", wen, 0);

    // Full load to RUN, then reset mid-RUN
    start = 1; tick; start = 0;
    chk("ld2.aborted", aborted, 0);
    load_all(0, 1);
    wait_cen(n);
    chk("arm2.cycles", n, 8);
    wen7 = 1; tick; wen7 = 0;
    chk("lock2.set", locked, 1);
    reset = 0; tick; reset = 1;
    chk_all_zero("rst_run");

    // Reset mid-LOAD does not set aborted
    start = 1; tick; start = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = 48'(i); tick;
    end
    reset = 0; tick; reset = 1; s_valid = 0;
    chk_all_zero("rst_load");
    tick;
    chk("rst_load.idle", busy, 0);

`ifdef CORDIC_LOAD_CHECKSUM_EN
    // Bad checksum: back to IDLE, cen never rises
    chk_exp = good_chk ^ 48'h1;
    start = 1; tick; start = 0;
    load_all(0, 0);
    chk("chk.err", chk_err, 1);
    wait_cen(n);
    chk("chk.no_cen", n, 20);
    chk("chk.err_hold", chk_err, 1);
    // Good checksum proceeds to RUN
    chk_exp = good_chk;
    start = 1; tick; start = 0;
    chk("chk.err_clr", chk_err, 0);
    load_all(0, 1);
    wait_cen(n);
    chk("chk.run", n, 8);
    chk("chk.err_ok", chk_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_load_seq.md
CORDIC_LOAD_SEQ -- requirements
Module: cordic_load_seq

Interface
REQ-001 Parameter: LAST_INDEX, 63, index of final table entry written per load (range 0..63).
REQ-002 Parameter: ARM_WAIT, 8, cycles in ARM before cen asserts (range 1..255).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 start  in  1  pulse: begin table load.
REQ-006 stop  in  1  pulse: halt/abort to IDLE.
REQ-007 s_valid  in  1  table word valid.
REQ-008 s_data  in  48  table word.
REQ-009 s_ready  out  1  sequencer accepts table word.
REQ-010 fcw_in  in  16  requested frequency control word.
REQ-011 offset_in  in  16  requested phase offset.
REQ-012 cfg_upd  in  1  pulse: apply fcw_in/offset_in while running.
REQ-013 wen7  in  1  datapath output-valid strobe.
REQ-014 wen  out  1  table write enable to datapath.
REQ-015 index_wri  out  6  table write address.
REQ-016 D  out  48  table write data.
REQ-017 fcw  out  16  registered frequency control word.
REQ-018 offset  out  16  registered phase offset.
REQ-019 cen  out  1  datapath enable.
REQ-020 busy  out  1  high in LOAD or ARM.
REQ-021 locked  out  1  first wen7 seen in current RUN.
REQ-022 aborted  out  1  sticky: last sequence ended by stop before RUN.

Function
REQ-023 States IDLE, LOAD, ARM, RUN; one-hot or binary encoding, implementer's choice.
REQ-024 IDLE: s_ready=0, wen=0, cen=0; start=1 and stop=0 -> LOAD, write counter cleared to 0, aborted cleared.
REQ-025 LOAD: s_ready=1; each cycle with s_valid=1 is a handshake.
REQ-026 Handshake at cycle N -> cycle N+1: wen=1, D=s_data, index_wri=counter value at N; counter increments.
REQ-027 wen=0 in every cycle not following a handshake; D/index_wri hold last values.
REQ-028 Handshake with counter==LAST_INDEX -> ARM next cycle; s_ready=0 from that cycle; fcw/offset latched from fcw_in/offset_in on that same edge.
REQ-029 ARM: wait counter runs ARM_WAIT cycles, then RUN; cen=1 first cycle in RUN.
REQ-030 RUN: cen=1; cfg_upd=1 -> fcw/offset take fcw_in/offset_in next cycle; no other fcw/offset changes.
REQ-031 RUN: locked set the cycle after the first wen7=1; cleared on leaving RUN.
REQ-032 stop=1 in any state -> IDLE next cycle; cen, wen, s_ready, busy deassert that cycle; aborted=1 if stopped from LOAD or ARM.
REQ-033 Priority: stop over start, cfg_upd, handshake; word presented with stop is not written.
REQ-034 start outside IDLE ignored.
REQ-035 cfg_upd outside RUN ignored.
REQ-036 wen7 outside RUN ignored.

Reset
REQ-037 reset=0 at a clk edge -> IDLE; all outputs 0 (wen, index_wri, D, fcw, offset, cen, s_ready, busy, locked, aborted), counters 0.
REQ-038 Reset mid-LOAD or mid-RUN behaves identically; aborted not set by reset.

Configuration
REQ-039 Macro CORDIC_LOAD_CHECKSUM_EN defined: ports chk_exp (in, 48) and chk_err (out, 1) present.
REQ-040 With macro: running XOR of accepted words, cleared on start; at final handshake, compare with chk_exp.
REQ-041 With macro, mismatch: IDLE instead of ARM, chk_err=1 until next start or reset, cen never asserts; match proceeds to ARM.
REQ-042 Macro undefined: ports absent, no checksum logic, LOAD always proceeds to ARM.

Verification
REQ-043 Reset, start, 64 words s_data=i*3 with s_valid continuous -> wen high 64 consecutive cycles, index_wri 0..63, D matches; ARM 8 cycles; cen=1.
REQ-044 s_valid toggled 1/0 during load -> wen only after handshakes, index_wri gapless 0..63.
REQ-045 RUN with fcw=0x0100, cfg_upd with fcw_in=0x0200 -> fcw=0x0200 next cycle; wen7 pulse -> locked=1 next cycle.
REQ-046 stop at word 20 -> IDLE next cycle, aborted=1, no further wen; next start restarts at index 0, aborted=0.
REQ-047 start and stop same IDLE cycle -> stays IDLE; reset=0 mid-RUN -> all outputs 0 next cycle.
REQ-048 With CORDIC_LOAD_CHECKSUM_EN, chk_exp wrong by one bit -> chk_err=1, IDLE, cen stays 0; correct chk_exp -> RUN.
